mem_stage_wb_reg: RTL
=====================

// Module: mem_stage_wb_reg
// PURPOSE
//  MEM stage of the SPARC pipeline plus the MEM/WB register. Consumes EX/MEM outputs (load, rf_le, E, size, rw_dm),
//  runs one data-memory access per instruction over a req/ack bus, aligns and extends load data, and registers
//  the write-back result. Stalls upstream while an access is outstanding; watchdog turns a hung bus into an error.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles in WAIT with no dm_ack before bus error is raised (>=2)
//  CNT_W           7   timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1   clock, rising edge
//  R            in   1   reset, asynchronous, active-low
//  load_mem     in   1   instruction is a load
//  rf_le_mem    in   1   register-file write enable
//  E_mem        in   1   load sign-extend (1) / zero-extend (0)
//  size_mem     in   2   00 byte, 01 half, 10 word, 11 treated as word
//  rw_dm_mem    in   1   1 = store
//  addr_mem     in   32  effective address / ALU result
//  st_data_mem  in   32  store data (right-justified)
//  rd_mem       in   5   destination register
//  dm_req/dm_we out  1   memory request / write strobe
//  dm_addr      out  32  word address, bits [1:0] = 0
//  dm_be        out  4   byte enables, big-endian: be[3] = bits 31:24 = offset 0
//  dm_wdata     out  32  store data replicated into lanes
//  dm_ack       in   1   memory completes request this cycle
//  dm_rdata     in   32  read data, valid with dm_ack
//  stall_mem    out  1   hold IF..EX/MEM this cycle
//  bus_err      out  1   one-cycle pulse on watchdog expiry
//  trap_mem     out  1   one-cycle pulse on misaligned access (macro only)
//  rf_le_wb/rd_wb/wb_data out 1/5/32  MEM/WB register outputs
// BEHAVIOUR
//  - Reset (R=0): state IDLE, counter 0, rf_le_wb=0, rd_wb=0, wb_data=0, bus_err=0, trap_mem=0; dm_req=0.
//  - access = load_mem | rw_dm_mem. dm_req = access & (state IDLE|WAIT) & ~misaligned; combinational.
//  - Completion = dm_req & dm_ack. Zero-wait memory: done same cycle, no stall.
//  - stall_mem = dm_req & ~dm_ack.
//  - FSM IDLE: dm_req & ~dm_ack -> WAIT, counter cleared. WAIT: dm_ack -> IDLE; counter==TIMEOUT_CYCLES-1 -> IDLE,
//    bus_err pulses, instruction retires as bubble (rf_le_wb=0). dm_ack on expiry cycle wins: normal completion.
//  - Load extract: byte lane = addr[1:0] (0 = bits 31:24); half lane = addr[1] (0 = bits 31:16); extend by E_mem.
//  - Store: byte replicated x4, half x2; dm_be = 1000>>addr[1:0] (byte), 1100>>{addr[1],1'b0} (half), 1111 word.
//  - MEM/WB on posedge: if stall_mem, rf_le_wb<=0 (bubble), rd_wb/wb_data hold; else rf_le_wb<=rf_le_mem & ~fault,
//    rd_wb<=rd_mem, wb_data<= load_mem ? extended dm_rdata : addr_mem. fault = bus_err | trap_mem.
//  - load_mem & rw_dm_mem both 1: treated as store, no write-back data (wb_data=addr_mem).
//  - Reset mid-WAIT: FSM to IDLE immediately, dm_req drops; a later dm_ack in IDLE with no access is ignored.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no request, no stall,
//   trap_mem pulses one cycle, rf_le_wb<=0. Undefined: misaligned never true, low address bits ignored (access
//   forced to the containing aligned half/word), trap_mem tied 0.
// STRUCTURE
//  Package mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state enum {IDLE,WAIT}, lane/be constants.
//  Sub-module mem_lane_align: combinational store replicate + byte-enable gen + load extract/extend.
//  Top holds FSM, watchdog counter, MEM/WB register.
// TESTING
//  1 Load byte, E=1, addr=0x103, rdata=0x112233F0, ack same cycle -> no stall, wb_data=0xFFFFFFF0, rf_le_wb=1.
//  2 Store half, addr=0x202, data=0x0000ABCD -> dm_be=0011, dm_wdata=0xABCDABCD, dm_addr=0x200, dm_we=1.
//  3 Load word, ack after 3 cycles -> stall_mem high 3 cycles, rf_le_wb=0 during, then wb_data=rdata.
//  4 No ack, TIMEOUT_CYCLES=4 -> stall 4 cycles, bus_err 1 pulse, rf_le_wb=0, FSM IDLE.
//  5 Macro on, load word addr=0x101 -> dm_req=0, trap_mem pulse, rf_le_wb=0; macro off -> access 0x100, be=1111.
//  6 R low during WAIT -> all outputs reset values next sample; late dm_ack causes no write-back.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, byte-enable patterns.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Big-endian lanes: bit 3 of a byte enable covers data bits 31:24
    localparam logic [3:0] BE_BYTE = 4'b1000;
    localparam logic [3:0] BE_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Store lane replication, byte-enable generation and load extract/extend.
// Low address bits pick the lane; size 11 behaves as a word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic        is_byte;
    logic        is_half;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign is_byte = (size == SZ_BYTE);
    assign is_half = (size == SZ_HALF);

    // Lane 0 sits in the most significant bits
    assign bsel = rdata[{~addr_lo, 3'b000} +: 8];
    assign hsel = rdata[{~addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be      = BE_WORD;
        wdata   = st_data;
        ld_data = rdata;
        unique case (1'b1)
            is_byte: begin
                be      = BE_BYTE >> addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{sign_ext & bsel[7]}}, bsel};
            end
            is_half: begin
                be      = BE_HALF >> {addr_lo[1], 1'b0};
                wdata   = {2{st_data[15:0]}};
                ld_data = {{16{sign_ext & hsel[15]}}, hsel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_wb_reg.sv
// MEM stage: req/ack data-memory access with watchdog, plus the MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module mem_stage_wb_reg
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        R,
    input  logic        load_mem,
    input  logic        rf_le_mem,
    input  logic        E_mem,
    input  logic [1:0]  size_mem,
    input  logic        rw_dm_mem,
    input  logic [31:0] addr_mem,
    input  logic [31:0] st_data_mem,
    input  logic [4:0]  rd_mem,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_mem,
    output logic        bus_err,
    output logic        trap_mem,
    output logic        rf_le_wb,
    output logic [4:0]  rd_wb,
    output logic [31:0] wb_data
);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              access;
    logic              misaligned;
    logic              expire;
    logic              fault;
    logic              ld_wb;
    logic [31:0]       ld_data;

    assign access = load_mem | rw_dm_mem;
    assign ld_wb  = load_mem & ~rw_dm_mem;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = ((size_mem == SZ_HALF) & addr_mem[0])
                      | (size_mem[1] & (addr_mem[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign dm_req   = R & access & ~misaligned;
    assign dm_we    = dm_req & rw_dm_mem;
    assign dm_addr  = {addr_mem[31:2], 2'b00};
    assign trap_mem = R & access & misaligned;

    // A late ack on the final watchdog cycle still completes normally
    assign expire    = dm_req & ~dm_ack & (state == WAIT)
                     & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err   = expire;
    assign stall_mem = dm_req & ~dm_ack & ~expire;
    assign fault     = bus_err | trap_mem;

    mem_lane_align u_align (
        .size     (size_mem),
        .addr_lo  (addr_mem[1:0]),
        .sign_ext (E_mem),
        .st_data  (st_data_mem),
        .rdata    (dm_rdata),
        .be       (dm_be),
        .wdata    (dm_wdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (stall_mem) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                if (~stall_mem) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            rf_le_wb <= 1'b0;
            rd_wb    <= '0;
            wb_data  <= '0;
        end else if (stall_mem) begin
            rf_le_wb <= 1'b0;
        end else begin
            rf_le_wb <= rf_le_mem & ~fault;
            rd_wb    <= rd_mem;
            wb_data  <= ld_wb ? ld_data : addr_mem;
        end
    end

endmodule
